// File: rtl/sys_ctrl_pkg.sv
// Shared definitions for the system controller: command codes, FSM states,
// error causes and the result-serialisation word count.
package sys_ctrl_pkg;

  localparam logic [7:0] CMD_WR      = 8'hAA;
  localparam logic [7:0] CMD_RD      = 8'hBB;
  localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
  localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

  typedef enum logic [3:0] {
    IDLE,
    W_ADDR,
    W_DATA,
    R_ADDR,
    R_WAIT,
    OP_A,
    OP_B,
    FUN,
    A_WAIT,
    PUSH
  } state_e;

  typedef enum logic [2:0] {
    ERR_NONE,
    ERR_CMD,
    ERR_ADDR,
    ERR_FUN,
    ERR_TIMEOUT,
    ERR_BUSY
  } err_cause_e;

  function automatic int n_words(input int out_w, input int data_w);
    return (out_w + data_w - 1) / data_w;
  endfunction

endpackage

// File: rtl/frame_timer.sv
// Mid-frame inactivity timer: counts enabled cycles, cleared by any accepted
// event, and flags the cycle on which the idle run reaches its limit.
module frame_timer #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // cnt holds completed idle cycles; counting the current one makes
  // TIMEOUT_CYCLES-1, so the registered ERR lands TIMEOUT_CYCLES cycles
  // after the last accepted event.
  assign expire = en && !clr && (cnt == CNT_W'(TIMEOUT_CYCLES - 2));

endmodule

// File: rtl/sys_ctrl_gen2.sv
// Command-frame parser driving register file, gated ALU and TX FIFO,
// with inactivity timeout, error pulses and FIFO backpressure.
module sys_ctrl_gen2
  import sys_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 4,
  parameter int FUN_WIDTH      = 4,
  parameter int ALU_OUT_WIDTH  = 16,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int OP_A_ADDR      = 0,
  parameter int OP_B_ADDR      = 1
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [DATA_WIDTH-1:0]    RX_DATA,
  input  logic                     RX_VALID,
  input  logic                     FIFO_FULL,
  output logic [DATA_WIDTH-1:0]    WR_DATA,
  output logic                     WR_INC,
  output logic [ADDR_WIDTH-1:0]    REG_ADDR,
  output logic [DATA_WIDTH-1:0]    REG_WDATA,
  output logic                     REG_WR_EN,
  output logic                     REG_RD_EN,
  input  logic [DATA_WIDTH-1:0]    RD_DATA,
  input  logic                     RD_VALID,
  output logic [FUN_WIDTH-1:0]     ALU_FUN,
  output logic                     ALU_EN,
  output logic                     GATE_EN,
  input  logic [ALU_OUT_WIDTH-1:0] ALU_OUT,
  input  logic                     ALU_VALID,
  output logic                     ERR
);

  localparam int N_OUT  = n_words(ALU_OUT_WIDTH, DATA_WIDTH);
  localparam int BUF_W  = N_OUT * DATA_WIDTH;
  localparam int WCNT_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;

  state_e                state, state_n;
  err_cause_e            cause;
  logic [BUF_W-1:0]      out_buf, out_buf_n;
  logic [WCNT_W-1:0]     word_idx, word_idx_n;
  logic [WCNT_W-1:0]     word_last, word_last_n;
  logic [ADDR_WIDTH-1:0] reg_addr_q, reg_addr_n;
  logic [DATA_WIDTH-1:0] reg_wdata_q, reg_wdata_n;
  logic [FUN_WIDTH-1:0]  alu_fun_q, alu_fun_n;
  logic                  reg_wr_en_q, reg_wr_en_n;
  logic                  reg_rd_en_q, reg_rd_en_n;
  logic                  alu_en_q, alu_en_n;
  logic                  gate_en_q, gate_en_n;
  logic                  err_q, err_n;
  logic                  frame_event, timed, tmr_clr, tmr_en, tmr_expire;

  function automatic logic is_cmd(input logic [DATA_WIDTH-1:0] b, input logic [7:0] code);
    return b == DATA_WIDTH'(code);
  endfunction

  function automatic logic addr_fits(input logic [DATA_WIDTH-1:0] b);
    return (b >> ADDR_WIDTH) == '0;
  endfunction

  function automatic logic fun_fits(input logic [DATA_WIDTH-1:0] b);
    return (b >> FUN_WIDTH) == '0;
  endfunction

  // Events that count as frame progress and so restart the idle timer
  always_comb begin
    frame_event = 1'b0;
    case (state)
      W_ADDR, W_DATA, R_ADDR, OP_A, OP_B, FUN: frame_event = RX_VALID;
      R_WAIT:                                  frame_event = RD_VALID;
      A_WAIT:                                  frame_event = ALU_VALID;
      default:                                 frame_event = 1'b0;
    endcase
  end

  assign timed   = (state != IDLE) && (state != PUSH);
  assign tmr_clr = !timed || frame_event;
  assign tmr_en  = timed && !frame_event;

  frame_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (CLK),
    .rst    (RST),
    .clr    (tmr_clr),
    .en     (tmr_en),
    .expire (tmr_expire)
  );

  always_comb begin
    state_n     = state;
    out_buf_n   = out_buf;
    word_idx_n  = word_idx;
    word_last_n = word_last;
    reg_addr_n  = reg_addr_q;
    reg_wdata_n = reg_wdata_q;
    alu_fun_n   = alu_fun_q;
    gate_en_n   = gate_en_q;
    reg_wr_en_n = 1'b0;
    reg_rd_en_n = 1'b0;
    alu_en_n    = 1'b0;
    cause       = ERR_NONE;

    case (state)
      IDLE: begin
        if (RX_VALID) begin
          if (is_cmd(RX_DATA, CMD_WR))           state_n = W_ADDR;
          else if (is_cmd(RX_DATA, CMD_RD))      state_n = R_ADDR;
          else if (is_cmd(RX_DATA, CMD_ALU_OP))  state_n = OP_A;
          else if (is_cmd(RX_DATA, CMD_ALU_NOP)) state_n = FUN;
          else                                   cause   = ERR_CMD;
        end
      end
      W_ADDR: begin
        if (RX_VALID) begin
          if (addr_fits(RX_DATA)) begin
            reg_addr_n = ADDR_WIDTH'(RX_DATA);
            state_n    = W_DATA;
          end else begin
            cause   = ERR_ADDR;
            state_n = IDLE;
          end
        end
      end
      W_DATA: begin
        if (RX_VALID) begin
          reg_wdata_n = RX_DATA;
          reg_wr_en_n = 1'b1;
          state_n     = IDLE;
        end
      end
      R_ADDR: begin
        if (RX_VALID) begin
          if (addr_fits(RX_DATA)) begin
            reg_addr_n  = ADDR_WIDTH'(RX_DATA);
            reg_rd_en_n = 1'b1;
            state_n     = R_WAIT;
          end else begin
            cause   = ERR_ADDR;
            state_n = IDLE;
          end
        end
      end
      R_WAIT: begin
        if (RX_VALID) cause = ERR_BUSY;
        if (RD_VALID) begin
          out_buf_n   = BUF_W'(RD_DATA);
          word_idx_n  = '0;
          word_last_n = '0;
          state_n     = PUSH;
        end
      end
      OP_A: begin
        if (RX_VALID) begin
          reg_addr_n  = ADDR_WIDTH'(OP_A_ADDR);
          reg_wdata_n = RX_DATA;
          reg_wr_en_n = 1'b1;
          state_n     = OP_B;
        end
      end
      OP_B: begin
        if (RX_VALID) begin
          reg_addr_n  = ADDR_WIDTH'(OP_B_ADDR);
          reg_wdata_n = RX_DATA;
          reg_wr_en_n = 1'b1;
          state_n     = FUN;
        end
      end
      FUN: begin
        if (RX_VALID) begin
          if (fun_fits(RX_DATA)) begin
            alu_fun_n = FUN_WIDTH'(RX_DATA);
            alu_en_n  = 1'b1;
            gate_en_n = 1'b1;
            state_n   = A_WAIT;
          end else begin
            cause   = ERR_FUN;
            state_n = IDLE;
          end
        end
      end
      A_WAIT: begin
        if (RX_VALID) cause = ERR_BUSY;
        if (ALU_VALID) begin
          gate_en_n   = 1'b0;
          out_buf_n   = BUF_W'(ALU_OUT);
          word_idx_n  = '0;
          word_last_n = WCNT_W'(N_OUT - 1);
          state_n     = PUSH;
        end
      end
      PUSH: begin
        if (RX_VALID) cause = ERR_BUSY;
        // A full FIFO simply stalls the current word in place
        if (!FIFO_FULL) begin
          out_buf_n = out_buf >> DATA_WIDTH;
          if (word_idx == word_last) state_n = IDLE;
          else word_idx_n = word_idx + WCNT_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase

    if (tmr_expire) begin
      cause     = ERR_TIMEOUT;
      gate_en_n = 1'b0;
      state_n   = IDLE;
    end

    err_n = (cause != ERR_NONE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= IDLE;
      out_buf     <= '0;
      word_idx    <= '0;
      word_last   <= '0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      alu_fun_q   <= '0;
      reg_wr_en_q <= 1'b0;
      reg_rd_en_q <= 1'b0;
      alu_en_q    <= 1'b0;
      gate_en_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state       <= state_n;
      out_buf     <= out_buf_n;
      word_idx    <= word_idx_n;
      word_last   <= word_last_n;
      reg_addr_q  <= reg_addr_n;
      reg_wdata_q <= reg_wdata_n;
      alu_fun_q   <= alu_fun_n;
      reg_wr_en_q <= reg_wr_en_n;
      reg_rd_en_q <= reg_rd_en_n;
      alu_en_q    <= alu_en_n;
      gate_en_q   <= gate_en_n;
      err_q       <= err_n;
    end
  end

  // WR_INC follows FIFO_FULL in the same cycle so no word is pushed into a full FIFO
  assign WR_INC    = (state == PUSH) && !FIFO_FULL;
  assign WR_DATA   = out_buf[DATA_WIDTH-1:0];
  assign REG_ADDR  = reg_addr_q;
  assign REG_WDATA = reg_wdata_q;
  assign REG_WR_EN = reg_wr_en_q;
  assign REG_RD_EN = reg_rd_en_q;
  assign ALU_FUN   = alu_fun_q;
  assign ALU_EN    = alu_en_q;
  assign GATE_EN   = gate_en_q;
  assign ERR       = err_q;

endmodule
